cv32e40px_x_result_arb: RTL and testbench

- Arbitrates result transactions from NUM_CP eXtension-interface coprocessors onto the core's single X-interface result channel.
- Sits between the coprocessors and the X dispatcher/ID stage. Fair round-robin arbitration, one registered output slot.
- Delivers results one per cycle at full throughput. Upstream sees per-coprocessor valid/ready handshakes.

---
 rtl/cv32e40px_x_result_arb.sv | 145 ++++++++++++++
 tb/tb_cv32e40px_x_result_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40px_x_result_arb.sv
// Round-robin merge of NUM_CP coprocessor result channels into one registered X-interface result slot.
// Define CV32E40PX_X_RES_STALL_CNT_EN to add stall_cnt_o, a saturating count of cycles with a blocked requester.
module cv32e40px_x_result_arb #(
   parameter int NUM_CP = 2,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4,
   parameter int SRC_W  = (NUM_CP > 1) ? $clog2(NUM_CP) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_CP-1:0]             cp_result_valid_i,
   output logic [NUM_CP-1:0]             cp_result_ready_o,
   input  logic [NUM_CP-1:0][ID_W-1:0]   cp_result_id_i,
   input  logic [NUM_CP-1:0][4:0]        cp_result_rd_i,
   input  logic [NUM_CP-1:0]             cp_result_we_i,
   input  logic [NUM_CP-1:0][DATA_W-1:0] cp_result_data_i,
   output logic                          x_result_valid_o,
   input  logic                          x_result_ready_i,
   output logic [ID_W-1:0]               x_result_id_o,
   output logic [4:0]                    x_result_rd_o,
   output logic                          x_result_we_o,
   output logic [DATA_W-1:0]             x_result_data_o,
   output logic [SRC_W-1:0]              x_result_src_o,
   output logic                          busy_o
`ifdef CV32E40PX_X_RES_STALL_CNT_EN
   ,
   output logic [15:0]                   stall_cnt_o
`endif
);

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [4:0]        rd;
      logic              we;
      logic [DATA_W-1:0] data;
      logic [SRC_W-1:0]  src;
   } slot_t;

   logic              valid_q, valid_d;
   slot_t             slot_q, slot_d;
   logic [SRC_W-1:0]  rr_q, rr_d;

   logic              load_en;
   logic              grant_vld;
   logic              grant_found;
   logic [SRC_W-1:0]  grant_idx;
   logic [SRC_W-1:0]  cand_idx;
   int                cand;

   // Search starts at rr_q and wraps; re-evaluated every cycle, so a requester
   // that drops valid before being granted simply loses its turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < NUM_CP; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= NUM_CP) begin
            cand = cand - NUM_CP;
         end
         cand_idx = SRC_W'(cand);
         if (!grant_found && cp_result_valid_i[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // A full slot can be refilled in the same cycle it drains, giving 1 result/cycle.
   assign load_en   = !valid_q || x_result_ready_i;
   assign grant_vld = rst_ni && load_en && grant_found;

   always_comb begin
      cp_result_ready_o = '0;
      for (int i = 0; i < NUM_CP; i++) begin
         cp_result_ready_o[i] = grant_vld && (grant_idx == SRC_W'(i));
      end
   end

   // Next-state: slot occupancy, captured payload and round-robin pointer.
   always_comb begin
      valid_d = valid_q;
      slot_d  = slot_q;
      rr_d    = rr_q;
      if (grant_vld) begin
         valid_d     = 1'b1;
         slot_d.id   = cp_result_id_i[grant_idx];
         slot_d.rd   = cp_result_rd_i[grant_idx];
         slot_d.we   = cp_result_we_i[grant_idx];
         slot_d.data = cp_result_data_i[grant_idx];
         slot_d.src  = grant_idx;
         rr_d        = (grant_idx == SRC_W'(NUM_CP - 1)) ? '0 : grant_idx + SRC_W'(1);
      end else if (valid_q && x_result_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         slot_q  <= '0;
         rr_q    <= '0;
      end else begin
         valid_q <= valid_d;
         slot_q  <= slot_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      x_result_valid_o = valid_q;
      x_result_id_o    = slot_q.id;
      x_result_rd_o    = slot_q.rd;
      x_result_we_o    = slot_q.we;
      x_result_data_o  = slot_q.data;
      x_result_src_o   = slot_q.src;
      busy_o           = valid_q || (|cp_result_valid_i);
   end

`ifdef CV32E40PX_X_RES_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        stalled;

   assign stalled     = |(cp_result_valid_i & ~cp_result_ready_o);
   assign stall_cnt_d = (stalled && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

   a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(cp_result_ready_o));

   a_hold_when_stalled : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (x_result_valid_o && !x_result_ready_i) |=> (x_result_valid_o && $stable(slot_q)));

endmodule

// File: tb/tb_cv32e40px_x_result_arb.sv
// Directed bench for cv32e40px_x_result_arb: a 2-channel and a 3-channel instance on one clock.
// Registered outputs are sampled 1 time unit after the rising edge, ready after input changes settle.
module tb_cv32e40px_x_result_arb;

   logic clk;
   logic rst_n;

   logic [1:0]        v2, rdy2, we2;
   logic [1:0][3:0]   id2;
   logic [1:0][4:0]   rd2;
   logic [1:0][31:0]  data2;
   logic              xr2, xv2, xwe2, busy2;
   logic [3:0]        xid2;
   logic [4:0]        xrd2;
   logic [31:0]       xdata2;
   logic [0:0]        xsrc2;

   logic [2:0]        v3, rdy3, we3;
   logic [2:0][3:0]   id3;
   logic [2:0][4:0]   rd3;
   logic [2:0][31:0]  data3;
   logic              xr3, xv3, xwe3, busy3;
   logic [3:0]        xid3;
   logic [4:0]        xrd3;
   logic [31:0]       xdata3;
   logic [1:0]        xsrc3;

`ifdef CV32E40PX_X_RES_STALL_CNT_EN
   logic [15:0]       cnt2, cnt3;
`endif

   int n_chk = 0;
   int n_err = 0;

   cv32e40px_x_result_arb #(.NUM_CP(2), .DATA_W(32), .ID_W(4)) u_dut2 (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .cp_result_valid_i (v2),
      .cp_result_ready_o (rdy2),
      .cp_result_id_i    (id2),
      .cp_result_rd_i    (rd2),
      .cp_result_we_i    (we2),
      .cp_result_data_i  (data2),
      .x_result_valid_o  (xv2),
      .x_result_ready_i  (xr2),
      .x_result_id_o     (xid2),
      .x_result_rd_o     (xrd2),
      .x_result_we_o     (xwe2),
      .x_result_data_o   (xdata2),
      .x_result_src_o    (xsrc2),
      .busy_o            (busy2)
`ifdef CV32E40PX_X_RES_STALL_CNT_EN
      ,
      .stall_cnt_o       (cnt2)
`endif
   );

   cv32e40px_x_result_arb #(.NUM_CP(3), .DATA_W(32), .ID_W(4)) u_dut3 (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .cp_result_valid_i (v3),
      .cp_result_ready_o (rdy3),
      .cp_result_id_i    (id3),
      .cp_result_rd_i    (rd3),
      .cp_result_we_i    (we3),
      .cp_result_data_i  (data3),
      .x_result_valid_o  (xv3),
      .x_result_ready_i  (xr3),
      .x_result_id_o     (xid3),
      .x_result_rd_o     (xrd3),
      .x_result_we_o     (xwe3),
      .x_result_data_o   (xdata3),
      .x_result_src_o    (xsrc3),
      .busy_o            (busy3)
`ifdef CV32E40PX_X_RES_STALL_CNT_EN
      ,
      .stall_cnt_o       (cnt3)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      v2 = '0; we2 = '0; id2 = '0; rd2 = '0; data2 = '0; xr2 = 1'b0;
      v3 = '0; we3 = '0; id3 = '0; rd3 = '0; data3 = '0; xr3 = 1'b0;

      // Reset: requests present but no ready may be given
      v2 = 2'b11;
      xr2 = 1'b1;
      #1;
      chk("rst_rdy_pre", rdy2, 2'b00);
      step();
      step();
      chk("rst_valid", xv2, 1'b0);
      chk("rst_rdy", rdy2, 2'b00);
      chk("rst_valid3", xv3, 1'b0);

      // Single requester on cp0
      rst_n = 1'b1;
      v2 = 2'b01;
      id2[0] = 4'd3;
      rd2[0] = 5'd5;
      we2[0] = 1'b1;
      data2[0] = 32'hDEADBEEF;
      #1;
      chk("single_rdy", rdy2, 2'b01);
      chk("single_busy", busy2, 1'b1);
      step();
      v2 = 2'b00;
      chk("single_valid", xv2, 1'b1);
      chk("single_id", xid2, 4'd3);
      chk("single_rd", xrd2, 5'd5);
      chk("single_we", xwe2, 1'b1);
      chk("single_data", xdata2, 32'hDEADBEEF);
      chk("single_src", xsrc2, 1'b0);
      #1;
      chk("single_rdy_idle", rdy2, 2'b00);
      step();
      chk("single_drain", xv2, 1'b0);
      chk("idle_busy", busy2, 1'b0);

      // Reset mid-operation while FULL; rr pointer is 1 at this point
      v2 = 2'b01;
      data2[0] = 32'h1234;
      xr2 = 1'b0;
      step();
      v2 = 2'b00;
      chk("mid_full", xv2, 1'b1);
      chk("mid_data", xdata2, 32'h1234);
      rst_n = 1'b0;
      v2 = 2'b11;
      xr2 = 1'b1;
      #1;
      chk("mid_rst_rdy", rdy2, 2'b00);
      step();
      chk("mid_rst_valid", xv2, 1'b0);
      rst_n = 1'b1;
      data2[0] = 32'hA0;
      data2[1] = 32'hB1;
      id2[1] = 4'd7;
      #1;
      chk("rr_ptr_after_rst", rdy2, 2'b01);

      // Round-robin with both valid and ready held: 0,1,0,1
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_src", xsrc2, (i % 2 == 1) ? 1'b1 : 1'b0);
         chk("rr_data", xdata2, (i % 2 == 1) ? 32'hB1 : 32'hA0);
         chk("rr_valid", xv2, 1'b1);
         chk("rr_rdy", rdy2, (i % 2 == 1) ? 2'b01 : 2'b10);
      end

      // Backpressure: slot holds cp1/B1, only cp1 requesting with new data
      xr2 = 1'b0;
      v2 = 2'b10;
      data2[1] = 32'hC2;
      #1;
      chk("bp_rdy0", rdy2, 2'b00);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_valid", xv2, 1'b1);
         chk("bp_src", xsrc2, 1'b1);
         chk("bp_data", xdata2, 32'hB1);
         chk("bp_rdy", rdy2, 2'b00);
      end
      xr2 = 1'b1;
      #1;
      chk("bp_release_rdy", rdy2, 2'b10);
      step();
      v2 = 2'b00;
      chk("bp_load_src", xsrc2, 1'b1);
      chk("bp_load_data", xdata2, 32'hC2);
      step();
      chk("bp_drain", xv2, 1'b0);

      // Wrap on 3 channels: grant cp1 makes rr=2, then cp0+cp2 -> cp2, then cp0
      xr3 = 1'b1;
      data3[0] = 32'h30; data3[1] = 32'h31; data3[2] = 32'h32;
      v3 = 3'b010;
      #1;
      chk("wrap_rdy1", rdy3, 3'b010);
      step();
      chk("wrap_src1", xsrc3, 2'd1);
      v3 = 3'b101;
      #1;
      chk("wrap_rdy2", rdy3, 3'b100);
      step();
      chk("wrap_src2", xsrc3, 2'd2);
      chk("wrap_data2", xdata3, 32'h32);
      chk("wrap_rdy0", rdy3, 3'b001);
      step();
      v3 = 3'b000;
      chk("wrap_src0", xsrc3, 2'd0);
      chk("wrap_data0", xdata3, 32'h30);
      step();
      chk("wrap_drain", xv3, 1'b0);

`ifdef CV32E40PX_X_RES_STALL_CNT_EN
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("cnt_rst", cnt2, 16'd0);
      v2 = 2'b11;
      xr2 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("cnt_inc", cnt2, 16'(k));
      end
      repeat (65530) @(posedge clk);
      #1;
      chk("cnt_fffe", cnt2, 16'hFFFE);
      step();
      chk("cnt_ffff", cnt2, 16'hFFFF);
      step();
      step();
      chk("cnt_sat", cnt2, 16'hFFFF);
      v2 = 2'b00;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
